// File: rtl/ahb_bram_ctrl_if.sv
// ahb_bram_ctrl_if: AHB-Lite address/data-phase bus between a master and the BRAM controller
// Signals: HSEL/HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HREADY driven by the master side,
// HREADYOUT/HRESP/HRDATA returned by the slave side.
interface ahb_bram_ctrl_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// ahb_bram_ctrl: zero-wait AHB-Lite slave driving a dual-port block RAM, with read-after-write forwarding
// Ports:
//   HCLK, HRESETn     clock (also clocks the RAM) and asynchronous active-low reset
//   ahb               AHB-Lite slave bus (select, address, control, write data, ready/resp/read data)
//   BRAM_WRADDR/WDATA/WRITE  RAM write port: word address, data, per-byte enables
//   BRAM_RDADDR       RAM read word address, taken straight from HADDR so the RAM samples it at the accept edge
//   BRAM_RDATA        RAM registered read data, valid in the read data phase
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_ctrl_if.slave        ahb,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WRITE,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [31:0]           BRAM_RDATA
);
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;
  state_t                state_q, state_d;
  logic                  wr_phase_q, wr_phase_d;
  logic                  rd_phase_q, rd_phase_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_strb_q, wr_strb_d;
  logic                  fwd_hit_q, fwd_hit_d;
  logic [3:0]            fwd_strb_q, fwd_strb_d;
  logic [31:0]           fwd_data_q, fwd_data_d;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic                  acc, legal;
  logic [3:0]            strb;
  logic [31:0]           rd_merged;
  assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
  // A transfer offered during either error cycle is ignored: the master is cancelling it.
  assign acc = (state_q == IDLE || state_q == DATA) & ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign legal = (ahb.HSIZE == 3'd0) |
                 ((ahb.HSIZE == 3'd1) & ~ahb.HADDR[0]) |
                 ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] == 2'b00));
  assign strb = ahb.HSIZE == 3'd0 ? 4'b0001 << ahb.HADDR[1:0] :
                ahb.HSIZE == 3'd1 ? (ahb.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_comb begin
    state_d    = state_q;
    wr_phase_d = 1'b0;
    rd_phase_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_strb_d  = wr_strb_q;
    fwd_hit_d  = 1'b0;
    fwd_strb_d = fwd_strb_q;
    fwd_data_d = fwd_data_q;
    case (state_q)
      ERR1: state_d = ERR2;
      ERR2: state_d = IDLE;
      default: begin
        state_d = !acc ? IDLE : legal ? DATA : ERR1;
        if (acc && legal) begin
          wr_phase_d = ahb.HWRITE;
          rd_phase_d = ~ahb.HWRITE;
          wr_addr_d  = haddr_word;
          wr_strb_d  = strb;
          // The RAM returns the pre-write word when a read lands on the word being written this cycle.
          fwd_hit_d  = wr_phase_q & ~ahb.HWRITE & (wr_addr_q == haddr_word);
          fwd_strb_d = wr_strb_q;
          fwd_data_d = ahb.HWDATA;
        end
      end
    endcase
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      wr_phase_q <= 1'b0;
      rd_phase_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_strb_q  <= 4'b0000;
      fwd_hit_q  <= 1'b0;
      fwd_strb_q <= 4'b0000;
      fwd_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      wr_phase_q <= wr_phase_d;
      rd_phase_q <= rd_phase_d;
      wr_addr_q  <= wr_addr_d;
      wr_strb_q  <= wr_strb_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_strb_q <= fwd_strb_d;
      fwd_data_q <= fwd_data_d;
    end
  end
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign rd_merged[8*i +: 8] = (fwd_hit_q & fwd_strb_q[i]) ? fwd_data_q[8*i +: 8] : BRAM_RDATA[8*i +: 8];
  end
  assign ahb.HREADYOUT = state_q != ERR1;
  assign ahb.HRESP     = state_q == ERR1 || state_q == ERR2;
  assign ahb.HRDATA    = rd_phase_q ? rd_merged : 32'h0;
  assign BRAM_WRITE    = wr_phase_q ? wr_strb_q : 4'b0000;
  assign BRAM_WRADDR   = wr_addr_q;
  assign BRAM_WDATA    = ahb.HWDATA;
  assign BRAM_RDADDR   = haddr_word;
endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// tb_ahb_bram_ctrl: scoreboard bench for ahb_bram_ctrl against a program-order memory model
module tb_ahb_bram_ctrl;
  localparam int AW = 14;
  typedef struct {
    bit          err;
    bit          wr;
    logic [3:0]  strb;
    logic [AW-1:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic [AW-1:0] BRAM_WRADDR, BRAM_RDADDR;
  logic [31:0]   BRAM_WDATA;
  logic [3:0]    BRAM_WRITE;
  logic [31:0]   BRAM_RDATA = 32'h0;
  logic [31:0]   bram    [2**AW];
  logic [31:0]   ref_mem [2**AW];
  exp_t          expq[$];
  logic [31:0]   pend_wd;
  int            tests = 0;
  int            failed = 0;
  ahb_bram_ctrl_if bus ();
  assign bus.HREADY = bus.HREADYOUT;
  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus),
    .BRAM_WRADDR(BRAM_WRADDR), .BRAM_WDATA(BRAM_WDATA), .BRAM_WRITE(BRAM_WRITE),
    .BRAM_RDADDR(BRAM_RDADDR), .BRAM_RDATA(BRAM_RDATA)
  );
  always #5 HCLK = ~HCLK;
  // Synchronous RAM with read-old-data on a same-edge collision.
  always @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (BRAM_WRITE[i]) bram[BRAM_WRADDR][8*i +: 8] <= BRAM_WDATA[8*i +: 8];
    BRAM_RDATA <= bram[BRAM_RDADDR];
  end
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endfunction
  // One bus cycle: present an address phase (or idle) together with the data of the previous write.
  task automatic issue(input bit v, input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    bit lg;
    int off, s, word;
    logic [3:0] st;
    exp_t e;
    bus.HSEL = v; bus.HTRANS = v ? 2'b10 : 2'b00; bus.HADDR = a; bus.HSIZE = sz; bus.HWRITE = w;
    bus.HWDATA = pend_wd;
    pend_wd = $urandom;
    lg = 1'b1;
    if (v) begin
      s = int'(sz); off = int'(a[1:0]); word = int'(a[AW+1:2]);
      lg = (s == 0) || (s == 1 && off % 2 == 0) || (s == 2 && off == 0);
      st = lg ? 4'(((1 << (1 << s)) - 1) << off) : 4'b0000;
      e.err = !lg; e.wr = w; e.strb = st; e.waddr = AW'(word); e.wdata = wd; e.rdata = 32'h0;
      if (lg && w) begin
        for (int i = 0; i < 4; i++) if (st[i]) ref_mem[word][8*i +: 8] = wd[8*i +: 8];
        pend_wd = wd;
      end
      if (lg && !w) e.rdata = ref_mem[word];
      expq.push_back(e);
    end
    @(posedge HCLK); #1;
    if (!lg) begin
      bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWDATA = pend_wd;
      repeat (2) begin @(posedge HCLK); #1; end
    end
  endtask
  task automatic idle();
    issue(1'b0, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask
  // Monitor: completes each data phase when HREADYOUT is high and checks it against the queue head.
  initial begin
    bit pend;
    int waits;
    exp_t e;
    pend = 1'b0; waits = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        pend = 1'b0; waits = 0; expq.delete();
      end else begin
        if (pend && !bus.HREADYOUT) begin
          waits++;
          chk("err_wait_resp", 32'(bus.HRESP), 32'h1);
          chk("err_wait_nowrite", 32'(BRAM_WRITE), 32'h0);
        end else if (pend) begin
          if (expq.size() == 0) begin
            tests++; failed++;
            $display("FAIL spurious_resp: got a response, expected none at %0t", $time);
          end else begin
            e = expq.pop_front();
            chk("resp", 32'(bus.HRESP), 32'(e.err));
            if (e.err) begin
              chk("err_waits", 32'(waits), 32'h1);
              chk("err_nowrite", 32'(BRAM_WRITE), 32'h0);
            end else begin
              chk("ok_waits", 32'(waits), 32'h0);
              if (e.wr) begin
                chk("wr_strb", 32'(BRAM_WRITE), 32'(e.strb));
                chk("wr_addr", 32'(BRAM_WRADDR), 32'(e.waddr));
                chk("wr_data", BRAM_WDATA, e.wdata);
              end else begin
                chk("rd_data", bus.HRDATA, e.rdata);
                chk("rd_nowrite", 32'(BRAM_WRITE), 32'h0);
              end
            end
          end
          waits = 0;
        end else begin
          chk("idle_hrdata", bus.HRDATA, 32'h0);
          chk("idle_nowrite", 32'(BRAM_WRITE), 32'h0);
          chk("idle_resp", 32'(bus.HRESP), 32'h0);
        end
        if (bus.HREADYOUT) pend = bus.HSEL & bus.HTRANS[1];
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] saved, a;
    logic [2:0] sz;
    bit v, w;
    for (int i = 0; i < 2**AW; i++) begin bram[i] = 32'h0; ref_mem[i] = 32'h0; end
    bram[4] = 32'h12345678; ref_mem[4] = 32'h12345678;
    bram[5] = 32'h9ABCDEF0; ref_mem[5] = 32'h9ABCDEF0;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HADDR = 32'h0; bus.HSIZE = 3'd0;
    bus.HWRITE = 1'b0; bus.HWDATA = 32'h0; pend_wd = 32'h0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("rst_hresp", 32'(bus.HRESP), 32'h0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_bram_write", 32'(BRAM_WRITE), 32'h0);
    chk("rst_bram_wraddr", 32'(BRAM_WRADDR), 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    issue(1, 1, 32'h100, 3'd2, 32'hDEADBEEF); idle();
    issue(1, 0, 32'h100, 3'd2, 32'h0); idle();
    issue(1, 1, 32'h201, 3'd0, 32'h00001100);
    issue(1, 1, 32'h202, 3'd1, 32'h33440000);
    issue(1, 0, 32'h200, 3'd2, 32'h0); idle();
    issue(1, 1, 32'h40, 3'd2, 32'hCAFEF00D);
    issue(1, 0, 32'h40, 3'd2, 32'h0); idle();
    issue(1, 1, 32'h12, 3'd1, 32'hAAAA0000);
    issue(1, 0, 32'h10, 3'd2, 32'h0); idle();
    issue(1, 1, 32'h12, 3'd1, 32'hBBBB0000);
    issue(1, 0, 32'h14, 3'd2, 32'h0); idle();
    issue(1, 1, 32'h102, 3'd2, 32'h55555555);
    issue(1, 0, 32'h100, 3'd2, 32'h0); idle();
    saved = ref_mem[12];
    issue(1, 1, 32'h30, 3'd2, 32'h5A5AA5A5);
    chk("rst_pre_write", 32'(BRAM_WRITE), 32'hF);
    #1 HRESETn = 1'b0;
    #1;
    chk("rst_mid_write", 32'(BRAM_WRITE), 32'h0);
    chk("rst_mid_hreadyout", 32'(bus.HREADYOUT), 32'h1);
    chk("rst_mid_hresp", 32'(bus.HRESP), 32'h0);
    ref_mem[12] = saved;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    issue(1, 0, 32'h30, 3'd2, 32'h0); idle();
    for (int n = 0; n < 500; n++) begin
      v = $urandom_range(0, 9) < 8;
      w = $urandom_range(0, 1) == 1;
      sz = $urandom_range(0, 19) == 0 ? 3'd3 : 3'($urandom_range(0, 2));
      a = ($urandom << 16) | 32'($urandom_range(0, 31));
      if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      issue(v, w, a, sz, $urandom);
    end
    repeat (3) idle();
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/ahb_bram_ctrl.md
Name: ahb_bram_ctrl

Overview:
- AHB-Lite slave directly upstream of the dual-port on-chip block RAM.
- Converts AHB address/data-phase transfers into the RAM's write-port signals (word address, byte enables, data) and read-port address, and returns RAM read data on HRDATA.
- Zero-wait-state for legal transfers.
- Forwards data on read-after-write to the same word, hiding the RAM's read-old-data behaviour.
- Returns a two-cycle ERROR on misaligned or oversized transfers.

Parameters:
ADDR_WIDTH, 14, RAM word-address width; decoded byte address bits are HADDR[ADDR_WIDTH+1:2]

Ports:
HCLK  in  1  system clock; also clocks the RAM
HRESETn  in  1  asynchronous active-low reset
HSEL  in  1  slave select
HADDR  in  32  byte address
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HSIZE  in  3  0=byte, 1=half, 2=word
HWRITE  in  1  1=write
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus ready (address phase sampled only when high)
HREADYOUT  out  1  slave ready
HRESP  out  1  0=OKAY, 1=ERROR
HRDATA  out  32  read data (data phase)
BRAM_WRADDR  out  ADDR_WIDTH  RAM write word address
BRAM_WDATA  out  32  RAM write data
BRAM_WRITE  out  4  RAM per-byte write enables
BRAM_RDADDR  out  ADDR_WIDTH  RAM read word address
BRAM_RDATA  in  32  RAM registered read data (1-cycle latency)

Behaviour:
- Interface: one clock (HCLK); reset HRESETn is asynchronous, active-low.
- Transfer accept: `acc = HSEL & HREADY & HTRANS[1]` at a rising edge.
- Legal transfers:
  - HSIZE=0: any alignment.
  - HSIZE=1: requires HADDR[0]=0.
  - HSIZE=2: requires HADDR[1:0]=0.
  - HSIZE>=3 is illegal.
- Byte strobes, decoded from HSIZE/HADDR[1:0]:
  - byte: 4'b0001<<HADDR[1:0].
  - half: 4'b0011<<{HADDR[1],1'b0}.
  - word: 4'b1111.
- States: IDLE, DATA, ERR1, ERR2. All state is registered and reset asynchronously.
  - IDLE/DATA + legal acc -> DATA. Latch wr_phase=HWRITE, rd_phase=~HWRITE, wr_addr=HADDR word bits, wr_strb.
  - IDLE/DATA + illegal acc -> ERR1. No RAM write.
  - IDLE/DATA + no acc -> IDLE, with wr_phase=rd_phase=0.
  - ERR1 -> ERR2 unconditionally. Outputs: HREADYOUT=0, HRESP=1.
  - ERR2 -> IDLE. Outputs: HREADYOUT=1, HRESP=1. A transfer presented while in ERR2 is ignored (the master cancels after ERROR).
  - All other states: HREADYOUT=1, HRESP=0.
- Write path, in the cycle after a write accept (data phase):
  - BRAM_WRITE = wr_strb if wr_phase, else 4'b0000.
  - BRAM_WRADDR = wr_addr.
  - BRAM_WDATA = HWDATA, combinational.
  - The RAM commits at the end of the data phase.
- Read path:
  - BRAM_RDADDR = HADDR[ADDR_WIDTH+1:2], combinational.
  - The RAM samples it at the accept edge, so BRAM_RDATA is valid in the data phase.
  - HRDATA = merged read data if rd_phase, else 32'h0.
- Forwarding:
  - Hit condition: in a write data phase, a read is accepted at the same edge to the same word (wr_addr == HADDR word bits).
  - On hit, register fwd_hit=1, fwd_strb=BRAM_WRITE, fwd_data=HWDATA. Otherwise fwd_hit=0.
  - In the next (read data) phase, each byte i of HRDATA = fwd_data byte i if fwd_hit & fwd_strb[i], else BRAM_RDATA byte i.
  - No hit to a different word; no forwarding across an intervening idle (the RAM already holds the data).
- Sub-word reads return the full word; the master selects lanes.
- Back-to-back writes: every cycle may be a data phase of one write and the address phase of the next; there are no bubbles.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, BRAM_WRITE=0, BRAM_WRADDR=0, state=IDLE, fwd_hit=0.
- Reset asserted mid-transfer aborts it immediately; no RAM write is issued after reset assertion.
- Unused HADDR upper bits are ignored; aliasing is the decoder's concern.

Test Plan:
1. Word write 0xDEADBEEF @0x100, idle, word read @0x100 -> BRAM_WRITE=4'hF and BRAM_WRADDR=0x40 in the write data phase; HRDATA=0xDEADBEEF.
2. Byte writes 0x11 @0x201, half 0x3344 @0x202, then word read @0x200 with RAM preloaded 0 -> strobes 4'b0010 then 4'b1100; HRDATA=0x33441100.
3. Word write 0xCAFEF00D @0x40 immediately followed (no idle) by word read @0x40, RAM old value 0x0 -> HRDATA=0xCAFEF00D; fwd_hit=1.
4. Half write 0xAAAA @0x12 immediately followed by read @0x10, old word 0x12345678 -> HRDATA=0xAAAA5678. Repeat with read @0x14 -> HRDATA=old @0x14, no forwarding.
5. Word write @0x102 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1; BRAM_WRITE stays 0; the next legal read gets OKAY.
6. Assert HRESETn low during a write data phase -> BRAM_WRITE=0 and HREADYOUT=1 immediately; the word at the target address is unchanged.
